// File: rtl/culsans_sram_arbiter.sv
// Round-robin arbiter that shares one single-ported SRAM between NumPorts
// requesters. Grants are combinational in the request cycle. Each accepted
// access, read or write, earns exactly one response pulse SramLatency cycles
// later. A small {valid, port} shift pipeline routes that pulse back to the
// port that issued the access.
//
// Handshake: a port presents req_i with its command. The access is accepted
// in the cycle that req_i[k] & gnt_o[k] is high, and nothing is queued. A
// port that is not granted must keep requesting; there is no hold-off
// buffer. rvalid_o[k] is a single-cycle pulse, and rdata_o is meaningful
// only while it is high. A response pulse is produced for writes as well.
module culsans_sram_arbiter #(
    parameter int NumPorts    = 4,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 64,
    parameter int SramLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            sram_req_o,
    output logic                            sram_we_o,
    output logic [AddrWidth-1:0]            sram_addr_o,
    output logic [DataWidth-1:0]            sram_wdata_o,
    output logic [DataWidth/8-1:0]          sram_be_o,
    input  logic [DataWidth-1:0]            sram_rdata_i
);

    localparam int BeWidth = DataWidth / 8;
    localparam int PtrW    = $clog2(NumPorts);

    typedef logic [PtrW-1:0] idx_t;

    localparam idx_t LastPort = idx_t'(NumPorts - 1);

    // Round-robin pointer: the port with the highest priority this cycle.
    idx_t rr_ptr;

    // Winner of the current arbitration round.
    idx_t gnt_idx;
    logic gnt_any;
    logic accept;

    // Scratch value for the rotating priority search.
    logic [PtrW:0] cand;

    // Response tracking: one slot per cycle of SRAM latency.
    logic pipe_valid [SramLatency];
    idx_t pipe_idx   [SramLatency];
    logic resp_valid;

    // Per-port views of the flattened command buses.
    logic [AddrWidth-1:0] addr_arr  [NumPorts];
    logic [DataWidth-1:0] wdata_arr [NumPorts];
    logic [BeWidth-1:0]   be_arr    [NumPorts];

    // Split the flattened per-port buses into indexable arrays.
    always_comb begin
        for (int k = 0; k < NumPorts; k++) begin
            addr_arr[k]  = addr_i[k*AddrWidth +: AddrWidth];
            wdata_arr[k] = wdata_i[k*DataWidth +: DataWidth];
            be_arr[k]    = be_i[k*BeWidth +: BeWidth];
        end
    end

    // Rotating priority search. The loop walks offsets from the lowest
    // priority to the highest, so the last requester it finds is the one
    // that wins.
    always_comb begin
        gnt_idx = rr_ptr;
        gnt_any = 1'b0;
        cand    = '0;
        for (int off = NumPorts - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr} + (PtrW+1)'(off);
            if (cand >= (PtrW+1)'(NumPorts)) begin
                cand = cand - (PtrW+1)'(NumPorts);
            end
            if (req_i[cand[PtrW-1:0]]) begin
                gnt_idx = cand[PtrW-1:0];
                gnt_any = 1'b1;
            end
        end
    end

    // Reset masks every grant, so nothing can be accepted while rst_i is high.
    assign accept = gnt_any & ~rst_i;

    // Grant vector and SRAM command mux. Outputs are zero when there is no winner.
    always_comb begin
        gnt_o        = '0;
        sram_req_o   = (|req_i) & ~rst_i;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (accept) begin
            gnt_o[gnt_idx] = 1'b1;
            sram_we_o      = we_i[gnt_idx];
            sram_addr_o    = addr_arr[gnt_idx];
            sram_wdata_o   = wdata_arr[gnt_idx];
            sram_be_o      = be_arr[gnt_idx];
        end
    end

    // Advance the round-robin pointer past the winner on each accepted access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_idx == LastPort) ? '0 : gnt_idx + idx_t'(1);
        end
    end

    // Shift the accepted port index along the latency pipeline. Reset clears
    // all slots, so accesses that are still in flight are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SramLatency; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_idx[i]   <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_idx[0]   <= gnt_idx;
            for (int i = 1; i < SramLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    // The last pipeline slot lines up with the SRAM read data.
    assign resp_valid = pipe_valid[SramLatency-1] & ~rst_i;

    // Steer the response pulse to its port and gate the shared read data.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (resp_valid) begin
            rvalid_o[pipe_idx[SramLatency-1]] = 1'b1;
            rdata_o                           = sram_rdata_i;
        end
    end

endmodule

// File: tb/tb_culsans_sram_arbiter.sv
// Bench for culsans_sram_arbiter. It runs directed scenarios with
// hand-computed expectations, then a long randomized phase. A queue-based
// reference model is checked against the DUT on every falling edge.
module tb_culsans_sram_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BW  = DW / 8;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic [NP-1:0]     req_i;
  logic [NP-1:0]     we_i;
  logic [NP*AW-1:0]  addr_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP*BW-1:0]  be_i;
  logic [NP-1:0]     gnt_o;
  logic [NP-1:0]     rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              sram_req_o;
  logic              sram_we_o;
  logic [AW-1:0]     sram_addr_o;
  logic [DW-1:0]     sram_wdata_o;
  logic [BW-1:0]     sram_be_o;
  logic [DW-1:0]     sram_rdata_i;

  culsans_sram_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .SramLatency(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // ---------------- scoreboard state ----------------
  // Expected responses in grant order: {due_cycle[31:0], port[7:0]}.
  logic [39:0] exp_q[$];
  int          rr_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_port(input int k, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
    we_i[k]            = we;
    addr_i[k*AW +: AW] = a;
    wdata_i[k*DW +: DW] = d;
    be_i[k*BW +: BW]   = b;
  endtask

  // ---------------- reference model + compare ----------------
  always @(negedge clk) begin : model_cmp
    logic [NP-1:0] e_gnt;
    logic [NP-1:0] e_rv;
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd;
    logic [BW-1:0] e_be;
    logic          due_now;
    int            g;
    e_gnt = '0; e_rv = '0; e_req = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
    g = -1;
    due_now = (exp_q.size() > 0) && (int'(exp_q[0][39:8]) == cyc);
    if (rst_i === 1'b0) begin
      // The first requester found, scanning upward from rr_m with wraparound, wins.
      for (int off = 0; off < NP; off++) begin
        int p;
        p = (rr_m + off) % NP;
        if (g < 0 && req_i[p]) g = p;
      end
      e_req = |req_i;
      if (g >= 0) begin
        e_gnt[g] = 1'b1;
        e_we     = we_i[g];
        e_addr   = addr_i[g*AW +: AW];
        e_wd     = wdata_i[g*DW +: DW];
        e_be     = be_i[g*BW +: BW];
      end
      if (due_now) begin
        e_rv[exp_q[0][7:0]] = 1'b1;
        e_rd = sram_rdata_i;
      end
    end
    chk("gnt", 64'(gnt_o), 64'(e_gnt));
    chk("rvalid", 64'(rvalid_o), 64'(e_rv));
    chk("rdata", rdata_o, e_rd);
    chk("sram_req", 64'(sram_req_o), 64'(e_req));
    chk("sram_we", 64'(sram_we_o), 64'(e_we));
    chk("sram_addr", 64'(sram_addr_o), 64'(e_addr));
    chk("sram_wdata", sram_wdata_o, e_wd);
    chk("sram_be", 64'(sram_be_o), 64'(e_be));
    // Advance the model to the next clock edge.
    if (rst_i !== 1'b0) begin
      rr_m = 0;
      exp_q.delete();
    end else begin
      if (due_now) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back({32'(cyc + LAT), 8'(g)});
        rr_m = (g + 1) % NP;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; req_i = '1; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    sram_rdata_i = 64'h1234_5678_9ABC_DEF0;

    // Reset forces every output low, even with all ports requesting.
    tick(); tick(); settle();
    chk("reset_gnt", 64'(gnt_o), 64'h0);
    chk("reset_sram_req", 64'(sram_req_o), 64'h0);
    chk("reset_rvalid", 64'(rvalid_o), 64'h0);
    chk("reset_rdata", rdata_o, 64'h0);
    tick();

    // All ports request for 8 cycles: grants go 0,1,2,3,0,1,2,3.
    rst_i = 1'b0;
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("rr_all", 64'(gnt_o), 64'(4'b0001 << (i % 4)));
      tick();
    end

    // The pointer is back at 0. Grant port 0 once to move the pointer to 1,
    // then requests from ports 3 and 0 are served in the order 3, 0.
    req_i = 4'b0001; settle(); chk("skip_setup", 64'(gnt_o), 64'h1); tick();
    req_i = 4'b1001; settle(); chk("skip_p3", 64'(gnt_o), 64'h8); tick();
    req_i = 4'b1001; settle(); chk("skip_p0", 64'(gnt_o), 64'h1); tick();
    req_i = 4'b0011; settle(); chk("skip_ptr1", 64'(gnt_o), 64'h2); tick();
    req_i = '0;
    repeat (LAT + 1) tick();

    // Ports 0,1,2 are granted in consecutive cycles. Their responses follow
    // LAT, LAT+1 and LAT+2 cycles after the first grant.
    for (int i = 0; i < LAT + 4; i++) begin
      req_i = (i < 3) ? 4'(4'b0001 << i) : 4'b0000;
      settle();
      if (i < 3) chk("pipe_gnt", 64'(gnt_o), 64'(4'b0001 << i));
      if (i >= LAT && i < LAT + 3) chk("pipe_rvalid", 64'(rvalid_o), 64'(4'b0001 << (i - LAT)));
      tick();
    end
    repeat (LAT) tick();

    // Single read from port 2 at address 0x100.
    set_port(2, 1'b0, 32'h100, 64'h0, 8'h00);
    req_i = 4'b0100;
    for (int i = 0; i <= LAT; i++) begin
      if (i == LAT) sram_rdata_i = 64'hDEAD_BEEF;
      settle();
      if (i == 0) begin
        chk("rd_gnt", 64'(gnt_o), 64'h4);
        chk("rd_addr", 64'(sram_addr_o), 64'h100);
        chk("rd_we", 64'(sram_we_o), 64'h0);
      end
      if (i == LAT) begin
        chk("rd_rvalid", 64'(rvalid_o), 64'h4);
        chk("rd_rdata", rdata_o, 64'hDEAD_BEEF);
      end
      tick();
      req_i = '0;
    end
    repeat (LAT) tick();

    // Write from port 3: the command appears on the SRAM bus in the same cycle.
    set_port(3, 1'b1, 32'h40, 64'hA5, 8'h01);
    req_i = 4'b1000;
    for (int i = 0; i <= LAT; i++) begin
      settle();
      if (i == 0) begin
        chk("wr_we", 64'(sram_we_o), 64'h1);
        chk("wr_addr", 64'(sram_addr_o), 64'h40);
        chk("wr_be", 64'(sram_be_o), 64'h01);
        chk("wr_wdata", sram_wdata_o, 64'hA5);
      end
      if (i == LAT) chk("wr_rvalid", 64'(rvalid_o), 64'h8);
      tick();
      req_i = '0;
    end
    repeat (LAT) tick();

    // Reset in the cycle after a port 1 grant drops that response. After
    // reset the pointer is 0, so a request from ports 1 and 2 goes to port 1.
    req_i = 4'b0010; settle(); chk("rst_pre_gnt", 64'(gnt_o), 64'h2); tick();
    rst_i = 1'b1; req_i = '0; settle(); chk("rst_drop_c1", 64'(rvalid_o), 64'h0); tick();
    rst_i = 1'b0; req_i = 4'b0110; settle(); chk("rst_post_gnt", 64'(gnt_o), 64'h2); tick();
    req_i = '0;
    for (int i = 3; i <= LAT + 1; i++) begin
      settle();
      chk("rst_drop", 64'(rvalid_o), 64'h0);
      tick();
    end
    repeat (LAT + 2) tick();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      req_i = 4'($urandom_range(0, 15));
      for (int k = 0; k < NP; k++) begin
        set_port(k, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      end
      sram_rdata_i = {$urandom, $urandom};
      tick();
    end
    rst_i = 1'b0;
    req_i = '0;
    repeat (LAT + 2) tick();

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
